// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with one-entry instruction buffer
//
// Owns the program counter, runs the instruction-memory req/ack handshake
// (one outstanding request), holds one fetched instruction until decode
// takes it, and applies exception / eret / branch redirects, including ones
// that arrive while a fetch is still outstanding.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   synchronous active-high reset
//   Stall      in   decode cannot accept an instruction this cycle
//   BrTaken    in   taken branch/jump redirect
//   BrTarget   in   [31:0] branch/jump target
//   ExcReq     in   exception redirect to EXC_VECTOR
//   EretReq    in   return-from-exception redirect
//   EpcIn      in   [31:0] eret target
//   ImemReq    out  fetch request
//   ImemAddr   out  [31:0] fetch address (current Pc)
//   ImemAck    in   memory completes the request this cycle
//   ImemRdata  in   [31:0] instruction word, valid with ImemAck
//   InstrValid out  Instr/InstrPc valid for decode
//   Instr      out  [31:0] buffered instruction
//   InstrPc    out  [31:0] address of buffered instruction

module fetch_ctrl #(
  parameter logic [31:0] PC_BEGIN   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic        ExcReq,
  input  logic        EretReq,
  input  logic [31:0] EpcIn,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] instr_reg;
  logic [31:0] instr_pc;

  logic        redir_now;
  logic [31:0] redir_now_target;
  logic        redir_any;
  logic [31:0] redir_any_target;

  // Same-cycle redirect, priority exception > eret > branch, word aligned.
  always_comb begin
    redir_now        = ExcReq | EretReq | BrTaken;
    redir_now_target = BrTarget;
    if (ExcReq) begin
      redir_now_target = EXC_VECTOR;
    end else if (EretReq) begin
      redir_now_target = EpcIn;
    end
    redir_now_target = redir_now_target & ~32'h0000_0003;
  end

  // A redirect seen this cycle is newer than any pending one, so it wins.
  always_comb begin
    redir_any        = redir_now | pend_valid;
    redir_any_target = redir_now ? redir_now_target : pend_target;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= PC_BEGIN;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      instr_reg   <= 32'h0;
      instr_pc    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (redir_now) begin
            pc <= redir_now_target;
          end
          state <= BUSY;
        end

        BUSY: begin
          if (!ImemAck) begin
            // Address must stay stable until ack; remember the redirect instead.
            if (redir_now) begin
              pend_valid  <= 1'b1;
              pend_target <= redir_now_target;
            end
          end else if (redir_any) begin
            // Returned word belongs to the abandoned path: drop it and refetch.
            pc         <= redir_any_target;
            pend_valid <= 1'b0;
          end else begin
            instr_reg <= ImemRdata;
            instr_pc  <= pc;
            pc        <= pc + 32'd4;
            state     <= FULL;
          end
        end

        FULL: begin
          if (redir_now) begin
            // Redirect beats Stall: buffered instruction is on the wrong path.
            pc    <= redir_now_target;
            state <= BUSY;
          end else if (!Stall) begin
            state <= BUSY;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ImemReq    = (state == BUSY);
  assign ImemAddr   = pc;
  assign InstrValid = (state == FULL);
  assign Instr      = instr_reg;
  assign InstrPc    = instr_pc;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer. Owns the program counter and drives the instruction-memory request/acknowledge handshake.
- Buffers one fetched instruction until the decode stage accepts it.
- Applies redirects (exception, eret, taken branch/jump), including redirects that arrive while a fetch is outstanding.
- Sits between the PC/next-PC logic and the IF/ID pipeline register.

Parameters:
- PC_BEGIN, 32'h3000, PC loaded on reset.
- EXC_VECTOR, 32'h4180, exception handler entry address.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  decode cannot accept an instruction this cycle.
- BrTaken  in  1  taken branch/jump redirect request.
- BrTarget  in  32  branch/jump target.
- ExcReq  in  1  exception redirect to EXC_VECTOR.
- EretReq  in  1  return-from-exception redirect.
- EpcIn  in  32  eret target.
- ImemReq  out  1  fetch request.
- ImemAddr  out  32  fetch address (= Pc).
- ImemAck  in  1  memory completes request this cycle.
- ImemRdata  in  32  instruction word, valid with ImemAck.
- InstrValid  out  1  Instr/InstrPc valid for decode.
- Instr  out  32  buffered instruction.
- InstrPc  out  32  address of buffered instruction.

Behaviour:
- Reset (synchronous, active-high) sets:
  - Pc=PC_BEGIN, state=IDLE, pending redirect cleared.
  - InstrReg=0, InstrPc=0.
  - Outputs: ImemReq=0, InstrValid=0, Instr=0, InstrPc=0, ImemAddr=PC_BEGIN.
  - Reset wins over every other input, including an ImemAck in the same cycle (the ack is ignored and the transaction dropped).
- Redirect priority within one cycle is ExcReq > EretReq > BrTaken. Targets are EXC_VECTOR, EpcIn and BrTarget respectively. Target bits [1:0] are forced to 0.
- "Redirect present" means any of ExcReq, EretReq or BrTaken this cycle, or a pending redirect latched earlier.
- Pc+4 wraps modulo 2^32.
- States:
  - IDLE: ImemReq=0. Next state BUSY unconditionally. A redirect in IDLE loads Pc with the target.
  - BUSY:
    - ImemReq=1. ImemAddr=Pc, held stable until ImemAck.
    - No ack, redirect this cycle: latch pending target; the newest redirect overwrites any older pending one. Pc is unchanged.
    - Ack, redirect present: discard ImemRdata, Pc<=target, clear pending, stay BUSY. The new request is issued the next cycle.
    - Ack, no redirect: InstrReg<=ImemRdata, InstrPc<=Pc, Pc<=Pc+4, go FULL.
  - FULL:
    - ImemReq=0, InstrValid=1.
    - Redirect this cycle: instruction dropped, Pc<=target, go BUSY. This holds even when Stall=1.
    - Else Stall=0: instruction accepted this cycle, go BUSY.
    - Else (Stall=1): hold all state.
- InstrValid is asserted only in FULL. Instr and InstrPc are stable while InstrValid=1.
- Handshake:
  - Exactly one outstanding request.
  - ImemReq never drops in BUSY before ack.
  - ImemAck outside BUSY is ignored.
- Latency:
  - Reset release to first ImemReq: 1 cycle.
  - Ack to InstrValid: 1 cycle.
  - Minimum throughput: one instruction per 2 cycles with zero-wait memory.

Test Plan:
- Reset high 2 cycles, then low; ImemAck tied 1, ImemRdata=32'h24080001, Stall=0 -> ImemReq rises 1 cycle after release with ImemAddr=32'h3000. InstrValid pulses with InstrPc=32'h3000, 32'h3004, 32'h3008 on alternate cycles.
- Stall=1 for 5 cycles while FULL with InstrPc=32'h3004 -> InstrValid stays 1, Instr/InstrPc unchanged, ImemReq=0. Release Stall -> next ImemAddr=32'h3008.
- Memory delays ack 3 cycles on ImemAddr=32'h3008; BrTaken=1, BrTarget=32'h3100 in wait cycle 1 -> ImemAddr holds 32'h3008 until ack, data discarded (no InstrValid), next ImemAddr=32'h3100.
- ExcReq, EretReq (EpcIn=32'h3020) and BrTaken all asserted in one FULL cycle with Stall=1 -> instruction dropped, next ImemAddr=32'h4180.
- Pc=32'hFFFFFFFC fetched and accepted -> next ImemAddr=32'h00000000. BrTarget=32'h3103 -> ImemAddr=32'h3100.
- Reset asserted in the same cycle as ImemAck in BUSY -> no InstrValid, ImemReq=0 next cycle, Pc=32'h3000.
